systolic_array: RTL and testbench



---
 rtl/systolic_pkg.sv | 13 +
 rtl/systolic_pe.sv | 42 ++++
 rtl/systolic_array.sv | 66 ++++++
 tb/tb_systolic_array.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and helpers for the output-stationary systolic multiplier.
// Optional synchronous clear is enabled by SYSTOLIC_ARRAY_CLEAR_EN.
package systolic_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int DIM_DEF   = 10;

   // Edges from first input until an N x N product is complete.
   function automatic int ready_cycles(input int n);
      return 3 * n - 2;
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: forwards A right, B down, accumulates A*B.
// Port clear exists only when SYSTOLIC_ARRAY_CLEAR_EN is defined.
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clock,
   input  logic               reset,
`ifdef SYSTOLIC_ARRAY_CLEAR_EN
   input  logic               clear,
`endif
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic [WIDTH-1:0]   a_out,
   output logic [WIDTH-1:0]   b_out,
   output logic [2*WIDTH-1:0] acc
);

   logic [2*WIDTH-1:0] prod;

   assign prod = {{WIDTH{1'b0}}, a_in} * {{WIDTH{1'b0}}, b_in};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
`ifdef SYSTOLIC_ARRAY_CLEAR_EN
      end else if (clear) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
`endif
      end else begin
         a_out <= a_in;
         b_out <= b_in;
         acc   <= acc + prod;
      end
   end

endmodule

// File: rtl/systolic_array.sv
// DIM x DIM output-stationary systolic matrix multiplier (C = A x B).
// Define SYSTOLIC_ARRAY_CLEAR_EN to add a synchronous clear port.
module systolic_array
   import systolic_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DIM   = DIM_DEF
) (
   input  logic               clock,
   input  logic               reset,
`ifdef SYSTOLIC_ARRAY_CLEAR_EN
   input  logic               clear,
`endif
   input  logic [WIDTH-1:0]   inp_left [DIM],
   input  logic [WIDTH-1:0]   inp_top  [DIM],
   output logic [2*WIDTH-1:0] result   [DIM][DIM]
);

   logic [WIDTH-1:0] a_w [DIM][DIM];
   logic [WIDTH-1:0] b_w [DIM][DIM];

   // Operands leaving the far edges have no consumer.
   logic edge_unused;

   always_comb begin
      edge_unused = 1'b0;
      for (int k = 0; k < DIM; k++) begin
         edge_unused = edge_unused ^ (^a_w[k][DIM-1]) ^ (^b_w[DIM-1][k]);
      end
   end

   for (genvar i = 0; i < DIM; i++) begin : g_row
      for (genvar j = 0; j < DIM; j++) begin : g_col
         logic [WIDTH-1:0] a_in;
         logic [WIDTH-1:0] b_in;

         if (j == 0) begin : g_a_edge
            assign a_in = inp_left[i];
         end else begin : g_a_nbr
            assign a_in = a_w[i][j-1];
         end

         if (i == 0) begin : g_b_edge
            assign b_in = inp_top[j];
         end else begin : g_b_nbr
            assign b_in = b_w[i-1][j];
         end

         systolic_pe #(
            .WIDTH (WIDTH)
         ) u_pe (
            .clock (clock),
            .reset (reset),
`ifdef SYSTOLIC_ARRAY_CLEAR_EN
            .clear (clear),
`endif
            .a_in  (a_in),
            .b_in  (b_in),
            .a_out (a_w[i][j]),
            .b_out (b_w[i][j]),
            .acc   (result[i][j])
         );
      end
   end

endmodule

// File: tb/tb_systolic_array.sv
// Scoreboard bench for systolic_array: software matmul model vs. DUT.
// Covers the clear port when SYSTOLIC_ARRAY_CLEAR_EN is defined.
module tb_systolic_array;

   localparam int W = 8;
   localparam int D = 10;

   typedef struct {
      string       tag;
      int          i;
      int          j;
      logic [15:0] val;
   } exp_t;

   logic          clock;
   logic          reset;
   logic          clear;
   logic [W-1:0]  inp_left [D];
   logic [W-1:0]  inp_top  [D];
   logic [2*W-1:0] result  [D][D];

   int total;
   int bad;
   exp_t sb[$];
   int ma [D][D];
   int mb [D][D];

   systolic_array #(
      .WIDTH (W),
      .DIM   (D)
   ) dut (
      .clock    (clock),
      .reset    (reset),
`ifdef SYSTOLIC_ARRAY_CLEAR_EN
      .clear    (clear),
`endif
      .inp_left (inp_left),
      .inp_top  (inp_top),
      .result   (result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic zero_inputs();
      for (int i = 0; i < D; i++) begin
         inp_left[i] = '0;
         inp_top[i]  = '0;
      end
   endtask

   task automatic clear_mats();
      for (int i = 0; i < D; i++)
         for (int j = 0; j < D; j++) begin
            ma[i][j] = 0;
            mb[i][j] = 0;
         end
   endtask

   // Skewed feed: A[i][k] at cycle k+i, B[k][j] at cycle k+j.
   task automatic drive(input int c, input int n);
      int k;
      for (int i = 0; i < D; i++) begin
         k = c - i;
         inp_left[i] = (k >= 0 && k < n) ? W'(ma[i][k]) : '0;
         inp_top[i]  = (k >= 0 && k < n) ? W'(mb[k][i]) : '0;
      end
   endtask

   task automatic feed(input int n, input int edges);
      for (int c = 0; c < edges; c++) begin
         @(negedge clock);
         drive(c, n);
      end
      @(negedge clock);
      zero_inputs();
   endtask

   task automatic push_model(input string name, input int n);
      int s;
      for (int i = 0; i < D; i++)
         for (int j = 0; j < D; j++) begin
            s = 0;
            for (int k = 0; k < n; k++) s += ma[i][k] * mb[k][j];
            sb.push_back('{$sformatf("%s[%0d][%0d]", name, i, j),
                           i, j, 16'(s % 65536)});
         end
   endtask

   task automatic push_const(input string name, input logic [15:0] v);
      for (int i = 0; i < D; i++)
         for (int j = 0; j < D; j++)
            sb.push_back('{$sformatf("%s[%0d][%0d]", name, i, j), i, j, v});
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, 32'(result[e.i][e.j]), 32'(e.val));
      end
   endtask

   task automatic load_3x3();
      clear_mats();
      ma[0][0] = 9; ma[0][1] = 3; ma[0][2] = 2;
      ma[1][0] = 5; ma[1][1] = 1; ma[1][2] = 1;
      ma[2][0] = 0; ma[2][1] = 1; ma[2][2] = 5;
      mb[0][0] = 9; mb[0][1] = 1; mb[0][2] = 8;
      mb[1][0] = 0; mb[1][1] = 2; mb[1][2] = 2;
      mb[2][0] = 2; mb[2][1] = 6; mb[2][2] = 1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      zero_inputs();
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      clear = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < D; i++) begin
         inp_left[i] = W'(i + 7);
         inp_top[i]  = W'(i + 3);
      end

      // Reset held with live inputs and clocks
      repeat (4) @(negedge clock);
      push_const("rst_hold", 16'h0);
      drain();
      reset = 1'b1;
      zero_inputs();
      repeat (5) @(negedge clock);
      push_const("rst_idle", 16'h0);
      drain();

      // 3x3 product
      load_3x3();
      push_model("mm3", 3);
      feed(3, 7);
      check("mm3_c00_const", 32'(result[0][0]), 32'd85);
      check("mm3_c12_const", 32'(result[1][2]), 32'd43);
      check("mm3_c21_const", 32'(result[2][1]), 32'd32);
      drain();
      repeat (3) @(negedge clock);
      push_model("mm3_stable", 3);
      drain();

      // Wrap of the 16-bit accumulator
      do_reset();
      drive(0, 0);
      inp_left[0] = 8'd255;
      inp_top[0]  = 8'd255;
      sb.push_back('{"wrap1", 0, 0, 16'((255 * 255) % 65536)});
      @(negedge clock);
      drain();
      sb.push_back('{"wrap2", 0, 0, 16'((2 * 255 * 255) % 65536)});
      sb.push_back('{"wrap_nb01", 0, 1, 16'h0});
      sb.push_back('{"wrap_nb10", 1, 0, 16'h0});
      @(negedge clock);
      zero_inputs();
      drain();

      // Full-size identity times B
      do_reset();
      clear_mats();
      for (int i = 0; i < D; i++) begin
         ma[i][i] = 1;
         for (int j = 0; j < D; j++) mb[i][j] = i * 10 + j;
      end
      push_model("ident", D);
      feed(D, 3 * D - 2);
      check("ident_c99_const", 32'(result[9][9]), 32'd99);
      check("ident_c47_const", 32'(result[4][7]), 32'd47);
      drain();

      // Reset asserted part-way through a product
      do_reset();
      load_3x3();
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         drive(c, 3);
      end
      @(negedge clock);
      check("mid_nonzero", 32'(result[0][0] != 0), 32'd1);
      zero_inputs();
      reset = 1'b0;
      #1;
      push_const("mid_rst", 16'h0);
      drain();
      @(negedge clock);
      reset = 1'b1;
      push_model("mid_rerun", 3);
      feed(3, 7);
      drain();

`ifdef SYSTOLIC_ARRAY_CLEAR_EN
      // Clear between two runs must not double the result
      do_reset();
      load_3x3();
      feed(3, 7);
      push_model("clr_first", 3);
      drain();
      for (int i = 0; i < D; i++) begin
         inp_left[i] = 8'd17;
         inp_top[i]  = 8'd23;
      end
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      zero_inputs();
      push_const("clr_zero", 16'h0);
      drain();
      push_model("clr_rerun", 3);
      feed(3, 7);
      drain();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
